// File: rtl/memu.sv
// memu: memory-access stage; aligns/extends load data and forwards the write-back value to IDU and WBU
module memu (
    input  logic        clk,
    input  logic        resetn,
    output logic        mem_allowin,
    input  logic        exe_to_mem_valid,
    input  logic [74:0] exe_to_mem_zip,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [69:0] mem_to_wb_zip,
    output logic [37:0] mem_rf_zip
);
    logic        mem_valid;
    logic        first;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [3:0]  mem_op;
    logic [31:0] pc;
    logic [31:0] rdata_buf;
    logic        accept;
    logic [31:0] ld_word;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign accept          = exe_to_mem_valid & mem_allowin;
    assign mem_allowin     = ~mem_valid | wb_allowin;
    assign mem_to_wb_valid = mem_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            first     <= 1'b0;
        end else begin
            if (mem_allowin) mem_valid <= exe_to_mem_valid;
            first <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) {res_from_mem, rf_we, rf_waddr, alu_result, mem_op, pc} <= exe_to_mem_zip;
        if (mem_valid & first) rdata_buf <= data_sram_rdata;
    end

    always_comb begin
        ld_word      = first ? data_sram_rdata : rdata_buf;
        off          = alu_result[1:0];
        ld_byte      = ld_word[8*off +: 8];
        ld_half      = off[1] ? ld_word[31:16] : ld_word[15:0];
        load_result  = mem_op[2:0] == 3'b000 ? {{24{~mem_op[3] & ld_byte[7]}}, ld_byte} :
                       mem_op[2:0] == 3'b001 ? {{16{~mem_op[3] & ld_half[15]}}, ld_half} : ld_word;
        final_result = res_from_mem ? load_result : alu_result;
    end

    assign mem_to_wb_zip = {rf_we, rf_waddr, final_result, pc};
    assign mem_rf_zip    = {mem_valid & rf_we, rf_waddr, final_result};
endmodule

// File: tb/tb_memu.sv
// tb_memu: directed self-checking bench for memu
module tb_memu;
    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_allowin;
    logic        exe_to_mem_valid;
    logic [74:0] exe_to_mem_zip;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_zip;
    logic [37:0] mem_rf_zip;
    int          n_run = 0;
    int          n_fail = 0;

    memu dut (
        .clk(clk),
        .resetn(resetn),
        .mem_allowin(mem_allowin),
        .exe_to_mem_valid(exe_to_mem_valid),
        .exe_to_mem_zip(exe_to_mem_zip),
        .data_sram_rdata(data_sram_rdata),
        .wb_allowin(wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid),
        .mem_to_wb_zip(mem_to_wb_zip),
        .mem_rf_zip(mem_rf_zip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [74:0] mk(input logic res, input logic we, input logic [4:0] waddr,
                                       input logic [31:0] alu, input logic [3:0] op, input logic [31:0] pc);
        return {res, we, waddr, alu, op, pc};
    endfunction

    task automatic load(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rdata);
        exe_to_mem_valid = 1'b1;
        exe_to_mem_zip   = mk(1'b1, 1'b1, 5'd3, alu, op, 32'h100);
        tick();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata  = rdata;
        #1;
    endtask

    initial begin
        resetn           = 1'b0;
        exe_to_mem_valid = 1'b0;
        exe_to_mem_zip   = '0;
        data_sram_rdata  = '0;
        wb_allowin       = 1'b1;
        tick();
        tick();
        check("rst_valid", 70'(mem_to_wb_valid), 70'd0);
        check("rst_allowin", 70'(mem_allowin), 70'd1);
        check("rst_fwd_we", 70'(mem_rf_zip[37]), 70'd0);
        resetn = 1'b1;
        tick();

        load(4'd0, 32'h1003, 32'h80FF1234);
        check("ldb_valid", 70'(mem_to_wb_valid), 70'd1);
        check("ldb_res", 70'(mem_to_wb_zip[63:32]), 70'hFFFFFF80);
        check("ldb_we", 70'(mem_to_wb_zip[69]), 70'd1);
        check("ldb_fwd", 70'(mem_rf_zip), {32'd0, 1'b1, 5'd3, 32'hFFFFFF80});
        tick();
        check("ldb_drain", 70'(mem_to_wb_valid), 70'd0);

        load(4'd9, 32'h2002, 32'h80FF1234);
        check("ldhu_res", 70'(mem_to_wb_zip[63:32]), 70'h000080FF);
        tick();
        load(4'd1, 32'h2000, 32'h80FF1234);
        check("ldh_res", 70'(mem_to_wb_zip[63:32]), 70'h00001234);
        tick();
        load(4'd1, 32'h2002, 32'h80FF1234);
        check("ldh_hi_res", 70'(mem_to_wb_zip[63:32]), 70'hFFFF80FF);
        tick();
        load(4'd8, 32'h2001, 32'h80FF1234);
        check("ldbu_res", 70'(mem_to_wb_zip[63:32]), 70'h00000012);
        tick();
        load(4'd0, 32'h2002, 32'h80FF1234);
        check("ldb_neg_res", 70'(mem_to_wb_zip[63:32]), 70'hFFFFFFFF);
        tick();

        wb_allowin = 1'b0;
        load(4'd2, 32'h3000, 32'hDEADBEEF);
        check("stall0_res", 70'(mem_to_wb_zip[63:32]), 70'hDEADBEEF);
        check("stall0_allowin", 70'(mem_allowin), 70'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_rdata = 32'h11111111;
            #1;
            check($sformatf("stall%0d_valid", i + 1), 70'(mem_to_wb_valid), 70'd1);
            check($sformatf("stall%0d_res", i + 1), 70'(mem_to_wb_zip[63:32]), 70'hDEADBEEF);
            check($sformatf("stall%0d_allowin", i + 1), 70'(mem_allowin), 70'd0);
        end
        wb_allowin = 1'b1;
        #1;
        check("release_allowin", 70'(mem_allowin), 70'd1);
        check("release_res", 70'(mem_to_wb_zip[63:32]), 70'hDEADBEEF);
        tick();
        check("release_drain", 70'(mem_to_wb_valid), 70'd0);

        exe_to_mem_valid = 1'b1;
        exe_to_mem_zip   = mk(1'b0, 1'b0, 5'd0, 32'h1000, 4'd6, 32'h140);
        tick();
        exe_to_mem_valid = 1'b0;
        check("st_res", 70'(mem_to_wb_zip[63:32]), 70'h1000);
        check("st_we", 70'(mem_to_wb_zip[69]), 70'd0);
        check("st_fwd_we", 70'(mem_rf_zip[37]), 70'd0);
        tick();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_zip   = mk(1'b0, 1'b1, 5'd7, 32'h5, 4'd0, 32'h144);
        tick();
        exe_to_mem_valid = 1'b0;
        check("add_zip", mem_to_wb_zip, {1'b1, 5'd7, 32'h5, 32'h144});
        check("add_fwd", 70'(mem_rf_zip), {32'd0, 1'b1, 5'd7, 32'h5});
        tick();

        for (int i = 0; i < 4; i++) begin
            exe_to_mem_valid = 1'b1;
            exe_to_mem_zip   = mk(1'b0, 1'b1, 5'(i + 1), 32'(i * 16), 4'd0, 32'h200 + 32'(i * 4));
            tick();
            check($sformatf("b2b%0d_valid", i), 70'(mem_to_wb_valid), 70'd1);
            check($sformatf("b2b%0d_zip", i), mem_to_wb_zip, {1'b1, 5'(i + 1), 32'(i * 16), 32'h200 + 32'(i * 4)});
        end
        exe_to_mem_valid = 1'b0;
        tick();
        check("b2b_drain", 70'(mem_to_wb_valid), 70'd0);

        load(4'd2, 32'h4000, 32'hCAFEF00D);
        check("rstmid_valid_before", 70'(mem_to_wb_valid), 70'd1);
        resetn = 1'b0;
        tick();
        check("rstmid_valid", 70'(mem_to_wb_valid), 70'd0);
        check("rstmid_allowin", 70'(mem_allowin), 70'd1);
        check("rstmid_fwd_we", 70'(mem_rf_zip[37]), 70'd0);
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
